uart_cmd_master: RTL
====================

Name: uart_cmd_master

Overview:
Initiator end of the 6-byte UART command protocol. Request frame: A5 cmd addr d0 d1 chk. Response frame: 5A status addr d0 d1 chk. chk is the XOR of the first five bytes.
- Accepts one command from a local requester and serialises the request frame onto a TX byte stream.
- Collects and validates the 5A response from the RX byte stream, with a timeout.
- Sits between an on-chip test sequencer/host-bridge and a UART TX/RX pair wired to the remote command responder.

Parameters:
TIMEOUT_CYCLES, 100000, clock cycles allowed from acceptance of request byte 5 (chk) to receipt of response byte 5; range 2..2^24-1
TO_W, 24, width of timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  system clock, single clock domain
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  requester has a command
req_ready  out  1  block idle, command accepted when req_valid&&req_ready
req_cmd  in  8  command byte (01 WR, 02 RD, 03 PING; not checked locally)
req_addr  in  8  address byte
req_data  in  16  payload; d0=req_data[7:0], d1=req_data[15:8]
tx_valid  out  1  byte available to UART TX
tx_data  out  8  byte to transmit
tx_ready  in  1  UART TX accepts byte when tx_valid&&tx_ready
rx_valid  in  1  one-cycle strobe, byte from UART RX (no backpressure)
rx_data  in  8  received byte
rsp_valid  out  1  one-cycle pulse, response/result available
rsp_err  out  2  0 OK, 1 TIMEOUT, 2 BADCHK
rsp_status  out  8  status byte from response (00 when rsp_err!=0)
rsp_addr  out  8  addr byte from response (00 when rsp_err!=0)
rsp_data  out  16  {d1,d0} from response (0000 when rsp_err!=0)
busy  out  1  high in any state other than IDLE

Behaviour:
- Async reset (rst_n low):
  - state=IDLE.
  - All outputs 0 except req_ready=1.
  - Counters and frame buffers cleared.
- Reset asserted mid-transaction aborts it; no rsp_valid is produced.
- FSM states: IDLE, SEND, WAIT_RSP, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid: latch cmd/addr/data, precompute chk = A5^cmd^addr^d0^d1, tx_idx=0, go to SEND.
  - req_ready falls the cycle after acceptance.
- SEND:
  - tx_valid=1; tx_data = byte[tx_idx] (A5, cmd, addr, d0, d1, chk).
  - First byte is presented in the cycle after acceptance.
  - tx_data is stable while tx_valid&&!tx_ready.
  - On tx_ready: tx_idx++, next byte presented the next cycle; back-to-back transfers allowed when tx_ready is held high.
  - After byte 5 is accepted: tx_valid=0, clear timeout counter and rx_idx, go to WAIT_RSP.
- WAIT_RSP, timeout:
  - Counter increments every cycle.
  - If counter reaches TIMEOUT_CYCLES before the frame completes: go to DONE with rsp_err=1.
  - If TIMEOUT and the 6th byte coincide in the same cycle, the byte wins (frame evaluated).
- WAIT_RSP, rx_idx==0 (SOF hunt): bytes other than 5A are discarded and the hunt continues.
- WAIT_RSP, rx_idx 1..4: bytes stored as status, addr, d0, d1; running XOR maintained.
- WAIT_RSP, rx_idx==5:
  - If rx_data == running XOR: rsp_err=0, fields loaded.
  - Else: rsp_err=2, fields zeroed.
  - Go to DONE.
- DONE: rsp_valid=1 for exactly one cycle with all rsp_* fields valid, then IDLE.
  - rsp_* fields hold their values until the next DONE.
  - req_ready=1 the cycle after rsp_valid.
- Bytes arriving in IDLE, SEND or DONE are ignored. No partial frame survives into the next transaction.
- Latency: PING with instant tx_ready and immediate response gives req accept → tx byte0 in 1 cycle; last rx byte → rsp_valid in 1 cycle.

Decomposition:
- Shared package uart_cmd_pkg holds:
  - SOF_REQ=8'hA5, SOF_RSP=8'h5A.
  - CMD_WR/RD/PING.
  - Status codes ST_OK=00, E1..E4.
  - Local RSP_ERR_* codes.
  - State enum.
- The responder block uses the same package.
- No sub-module; the FSM, TX mux and RX assembler fit in one file.

Test Plan:
- PING: req 03/00/0000 → tx A5 03 00 00 00 A6; feed 5A 00 01 15 00 4E → one rsp_valid, err=0, status=00, addr=01, data=0015.
- RD ID: req 02/00/0000 → tx A5 02 00 00 00 A7; feed 5A 00 00 34 4B 25 → err=0, data=4B34.
- Bad checksum: as RD ID but last byte 26 → err=2, status/addr/data=0; req_ready=1 next cycle.
- Timeout: TIMEOUT_CYCLES=100, no rx → rsp_valid err=1 exactly 100 cycles after chk byte accepted; late 5A frame afterwards ignored.
- Backpressure/resync: tx_ready toggled 1-of-3 → tx_data stable while stalled, byte sequence intact; feed 00 FF before a valid frame → garbage discarded, err=0.
- Reset mid-SEND after 3 bytes → tx_valid=0 immediately; req_ready=1, no rsp_valid; new request completes normally.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the 6-byte UART command protocol (master and responder).
// Frames: request A5 cmd addr d0 d1 chk, response 5A status addr d0 d1 chk.
package uart_cmd_pkg;

  localparam logic [7:0] SOF_REQ = 8'hA5;
  localparam logic [7:0] SOF_RSP = 8'h5A;

  localparam logic [7:0] CMD_WR   = 8'h01;
  localparam logic [7:0] CMD_RD   = 8'h02;
  localparam logic [7:0] CMD_PING = 8'h03;

  localparam logic [7:0] ST_OK = 8'h00;
  localparam logic [7:0] ST_E1 = 8'h01;
  localparam logic [7:0] ST_E2 = 8'h02;
  localparam logic [7:0] ST_E3 = 8'h03;
  localparam logic [7:0] ST_E4 = 8'h04;

  localparam logic [1:0] RSP_ERR_OK      = 2'd0;
  localparam logic [1:0] RSP_ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] RSP_ERR_BADCHK  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SEND     = 2'd1,
    S_WAIT_RSP = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  // Checksum over the first five bytes of either frame type.
  function automatic logic [7:0] frame_chk(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3,
                                           input logic [7:0] b4);
    return b0 ^ b1 ^ b2 ^ b3 ^ b4;
  endfunction

endpackage

// File: rtl/uart_cmd_master.sv
// Initiator end of the UART command protocol: serialises one request frame,
// then hunts for and validates the response frame under a timeout.
module uart_cmd_master
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned TO_W           = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_cmd,
  input  logic [7:0]  req_addr,
  input  logic [15:0] req_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rsp_valid,
  output logic [1:0]  rsp_err,
  output logic [7:0]  rsp_status,
  output logic [7:0]  rsp_addr,
  output logic [15:0] rsp_data,
  output logic        busy
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  state_t           state_reg, state_next;
  logic [7:0]       cmd_reg, cmd_next;
  logic [7:0]       addr_reg, addr_next;
  logic [7:0]       d0_reg, d0_next;
  logic [7:0]       d1_reg, d1_next;
  logic [7:0]       chk_reg, chk_next;
  logic [2:0]       tx_idx_reg, tx_idx_next;
  logic [2:0]       rx_idx_reg, rx_idx_next;
  logic [7:0]       rx_xor_reg, rx_xor_next;
  logic [7:0]       rx_status_reg, rx_status_next;
  logic [7:0]       rx_addr_reg, rx_addr_next;
  logic [7:0]       rx_d0_reg, rx_d0_next;
  logic [7:0]       rx_d1_reg, rx_d1_next;
  logic [TO_W-1:0]  to_cnt_reg, to_cnt_next;
  logic [TO_W-1:0]  to_cnt_inc;
  logic [1:0]       rsp_err_reg, rsp_err_next;
  logic [7:0]       rsp_status_reg, rsp_status_next;
  logic [7:0]       rsp_addr_reg, rsp_addr_next;
  logic [15:0]      rsp_data_reg, rsp_data_next;

  assign to_cnt_inc = to_cnt_reg + TO_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      cmd_reg        <= '0;
      addr_reg       <= '0;
      d0_reg         <= '0;
      d1_reg         <= '0;
      chk_reg        <= '0;
      tx_idx_reg     <= '0;
      rx_idx_reg     <= '0;
      rx_xor_reg     <= '0;
      rx_status_reg  <= '0;
      rx_addr_reg    <= '0;
      rx_d0_reg      <= '0;
      rx_d1_reg      <= '0;
      to_cnt_reg     <= '0;
      rsp_err_reg    <= '0;
      rsp_status_reg <= '0;
      rsp_addr_reg   <= '0;
      rsp_data_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      cmd_reg        <= cmd_next;
      addr_reg       <= addr_next;
      d0_reg         <= d0_next;
      d1_reg         <= d1_next;
      chk_reg        <= chk_next;
      tx_idx_reg     <= tx_idx_next;
      rx_idx_reg     <= rx_idx_next;
      rx_xor_reg     <= rx_xor_next;
      rx_status_reg  <= rx_status_next;
      rx_addr_reg    <= rx_addr_next;
      rx_d0_reg      <= rx_d0_next;
      rx_d1_reg      <= rx_d1_next;
      to_cnt_reg     <= to_cnt_next;
      rsp_err_reg    <= rsp_err_next;
      rsp_status_reg <= rsp_status_next;
      rsp_addr_reg   <= rsp_addr_next;
      rsp_data_reg   <= rsp_data_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cmd_next        = cmd_reg;
    addr_next       = addr_reg;
    d0_next         = d0_reg;
    d1_next         = d1_reg;
    chk_next        = chk_reg;
    tx_idx_next     = tx_idx_reg;
    rx_idx_next     = rx_idx_reg;
    rx_xor_next     = rx_xor_reg;
    rx_status_next  = rx_status_reg;
    rx_addr_next    = rx_addr_reg;
    rx_d0_next      = rx_d0_reg;
    rx_d1_next      = rx_d1_reg;
    to_cnt_next     = to_cnt_reg;
    rsp_err_next    = rsp_err_reg;
    rsp_status_next = rsp_status_reg;
    rsp_addr_next   = rsp_addr_reg;
    rsp_data_next   = rsp_data_reg;

    case (state_reg)
      S_IDLE: begin
        if (req_valid) begin
          cmd_next    = req_cmd;
          addr_next   = req_addr;
          d0_next     = req_data[7:0];
          d1_next     = req_data[15:8];
          chk_next    = frame_chk(SOF_REQ, req_cmd, req_addr, req_data[7:0], req_data[15:8]);
          tx_idx_next = '0;
          state_next  = S_SEND;
        end
      end

      S_SEND: begin
        if (tx_ready) begin
          if (tx_idx_reg == 3'd5) begin
            tx_idx_next = '0;
            rx_idx_next = '0;
            rx_xor_next = '0;
            to_cnt_next = '0;
            state_next  = S_WAIT_RSP;
          end else begin
            tx_idx_next = tx_idx_reg + 3'd1;
          end
        end
      end

      S_WAIT_RSP: begin
        to_cnt_next = to_cnt_inc;
        // The closing byte is evaluated ahead of the timeout so a frame finishing
        // on the deadline cycle still counts.
        if (rx_valid && (rx_idx_reg == 3'd5)) begin
          state_next = S_DONE;
          if (rx_data == rx_xor_reg) begin
            rsp_err_next    = RSP_ERR_OK;
            rsp_status_next = rx_status_reg;
            rsp_addr_next   = rx_addr_reg;
            rsp_data_next   = {rx_d1_reg, rx_d0_reg};
          end else begin
            rsp_err_next    = RSP_ERR_BADCHK;
            rsp_status_next = '0;
            rsp_addr_next   = '0;
            rsp_data_next   = '0;
          end
        end else begin
          if (rx_valid) begin
            if (rx_idx_reg == 3'd0) begin
              if (rx_data == SOF_RSP) begin
                rx_idx_next = 3'd1;
                rx_xor_next = rx_data;
              end
            end else begin
              case (rx_idx_reg)
                3'd1:    rx_status_next = rx_data;
                3'd2:    rx_addr_next   = rx_data;
                3'd3:    rx_d0_next     = rx_data;
                default: rx_d1_next     = rx_data;
              endcase
              rx_xor_next = rx_xor_reg ^ rx_data;
              rx_idx_next = rx_idx_reg + 3'd1;
            end
          end
          if (to_cnt_inc == TO_LIMIT) begin
            state_next      = S_DONE;
            rsp_err_next    = RSP_ERR_TIMEOUT;
            rsp_status_next = '0;
            rsp_addr_next   = '0;
            rsp_data_next   = '0;
          end
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    tx_data = 8'h00;
    if (state_reg == S_SEND) begin
      case (tx_idx_reg)
        3'd0:    tx_data = SOF_REQ;
        3'd1:    tx_data = cmd_reg;
        3'd2:    tx_data = addr_reg;
        3'd3:    tx_data = d0_reg;
        3'd4:    tx_data = d1_reg;
        default: tx_data = chk_reg;
      endcase
    end
  end

  assign req_ready  = (state_reg == S_IDLE);
  assign busy       = (state_reg != S_IDLE);
  assign tx_valid   = (state_reg == S_SEND);
  assign rsp_valid  = (state_reg == S_DONE);
  assign rsp_err    = rsp_err_reg;
  assign rsp_status = rsp_status_reg;
  assign rsp_addr   = rsp_addr_reg;
  assign rsp_data   = rsp_data_reg;

endmodule
